// File: rtl/syn_pipe_pkg.sv
// Shared types for the pipeline slice: stage flavour, stage occupancy state, capacity helper.
package syn_pipe_pkg;

  typedef enum logic [0:0] {
    PIPE_FULL = 1'b0,
    PIPE_FWD  = 1'b1
  } pipe_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  // Beats a chain of stages can hold: a skid stage holds two, a forward stage one.
  function automatic int unsigned pipe_cap(input pipe_mode_e mode, input int unsigned stages);
    return (mode == PIPE_FULL) ? 2 * stages : stages;
  endfunction

endpackage

// File: rtl/syn_pipe_stage.sv
// One valid/ready register slice: skid buffer with registered ready, or forward-registered stage.
module syn_pipe_stage
  import syn_pipe_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter pipe_mode_e  MODE = PIPE_FULL
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  stage_state_e state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         ready_q, ready_d;
  logic         in_xfer, out_xfer;
  logic         load_main_in, load_main_skid, load_skid;

  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = m_valid && m_ready;

  // State register; ready_q is "skid empty" in FULL mode and an out-of-reset enable in FWD mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and register-load decode
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    ready_d = (MODE == PIPE_FULL) ? (state_d != TWO) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= s_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= s_data;
      end
    end
  end

  // Outputs; only the FWD flavour lets m_ready reach s_ready
  always_comb begin
    m_valid = (state_q != EMPTY);
    m_data  = main_q;
    if (MODE == PIPE_FULL) begin
      s_ready = ready_q;
    end else begin
      s_ready = ready_q && ((state_q == EMPTY) || m_ready);
    end
  end

endmodule

// File: rtl/syn_pipe_slice.sv
// Chain of STAGES register slices with a beat-occupancy counter and synchronous flush.
module syn_pipe_slice
  import syn_pipe_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned STAGES = 2,
  parameter pipe_mode_e  MODE   = PIPE_FULL,
  localparam int unsigned CAP   = pipe_cap(MODE, STAGES),
  localparam int unsigned OCC_W = (CAP == 0) ? 1 : $clog2(CAP + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CH*DW-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CH*DW-1:0]   m_data,
  output logic [OCC_W-1:0]   occ
);

  localparam int unsigned BW = CH * DW;

  if (STAGES == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = &{1'b0, clk, rst_n, flush};
    assign m_valid = s_valid;
    assign m_data  = s_data;
    assign s_ready = m_ready;
    assign occ     = '0;
  end else begin : g_pipe
    logic [STAGES:0]  v;
    logic [STAGES:0]  r;
    logic [BW-1:0]    d [STAGES+1];
    logic [OCC_W-1:0] occ_q;
    logic             s_xfer, m_xfer;

    assign v[0] = s_valid;
    assign d[0] = s_data;
    assign r[STAGES] = m_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      syn_pipe_stage #(
        .W    (BW),
        .MODE (MODE)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (v[i]),
        .s_ready (r[i]),
        .s_data  (d[i]),
        .m_valid (v[i+1]),
        .m_ready (r[i+1]),
        .m_data  (d[i+1])
      );
    end

    // Upstream is refused during flush so no beat can be accepted and then wiped.
    assign s_ready = r[0] && !flush;
    assign m_valid = v[STAGES];
    assign m_data  = d[STAGES];

    assign s_xfer = s_valid && s_ready;
    assign m_xfer = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occ_q <= '0;
      end else if (flush) begin
        occ_q <= '0;
      end else if (s_xfer && !m_xfer) begin
        occ_q <= occ_q + OCC_W'(1);
      end else if (m_xfer && !s_xfer) begin
        occ_q <= occ_q - OCC_W'(1);
      end
    end

    assign occ = occ_q;
  end

endmodule

// File: tb/tb_syn_pipe_slice.sv
// Scoreboard bench: FULL (STAGES=2, CH=2), FWD (STAGES=3, CH=2) and bypass (STAGES=0) slices.
module tb_syn_pipe_slice;
  import syn_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // FULL instance
  logic        f_fl, f_sv, f_sr, f_mv, f_mr;
  logic [15:0] f_sd, f_md;
  logic [2:0]  f_occ;
  // FWD instance
  logic        w_fl, w_sv, w_sr, w_mv, w_mr;
  logic [15:0] w_sd, w_md;
  logic [1:0]  w_occ;
  // bypass instance
  logic        b_fl, b_sv, b_sr, b_mv, b_mr;
  logic [7:0]  b_sd, b_md;
  logic [0:0]  b_occ;

  syn_pipe_slice #(.DW(8), .CH(2), .STAGES(2), .MODE(PIPE_FULL)) u_full (
    .clk(clk), .rst_n(rst_n), .flush(f_fl), .s_valid(f_sv), .s_ready(f_sr), .s_data(f_sd),
    .m_valid(f_mv), .m_ready(f_mr), .m_data(f_md), .occ(f_occ));

  syn_pipe_slice #(.DW(8), .CH(2), .STAGES(3), .MODE(PIPE_FWD)) u_fwd (
    .clk(clk), .rst_n(rst_n), .flush(w_fl), .s_valid(w_sv), .s_ready(w_sr), .s_data(w_sd),
    .m_valid(w_mv), .m_ready(w_mr), .m_data(w_md), .occ(w_occ));

  syn_pipe_slice #(.DW(8), .CH(1), .STAGES(0), .MODE(PIPE_FULL)) u_byp (
    .clk(clk), .rst_n(rst_n), .flush(b_fl), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
    .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md), .occ(b_occ));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of accepted beats. Held-beat count is its size.
  typedef struct {
    logic [15:0] d;
    int          idx;
    bit          lat;
  } exp_t;

  exp_t        f_q[$];
  logic [15:0] w_q[$];
  exp_t        f_e;
  int          ncyc = 0;
  bit          lat_chk = 0;
  bit          f_hold = 0, w_hold = 0;
  logic [15:0] f_hold_d, w_hold_d;

  // Monitor: mid-cycle sampling sees exactly the handshakes the next rising edge will take.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      f_q.delete();
      w_q.delete();
      f_hold = 0;
      w_hold = 0;
    end else begin
      chk("full_occ", f_occ, f_q.size());
      if (f_q.size() == 4) chk("full_sready_at_cap", f_sr, 0);
      if (f_hold) begin
        chk("full_stall_valid", f_mv, 1);
        chk("full_stall_data", f_md, f_hold_d);
      end
      if (f_fl) begin
        f_q.delete();
        f_hold = 0;
      end else begin
        if (f_mv && f_mr) begin
          if (f_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL full_unexpected_beat: got %0h expected none", f_md);
          end else begin
            f_e = f_q.pop_front();
            chk("full_data", f_md, f_e.d);
            if (f_e.lat) chk("full_latency", ncyc - f_e.idx, 2);
          end
        end
        if (f_sv && f_sr) f_q.push_back('{d: f_sd, idx: ncyc, lat: lat_chk});
        f_hold   = f_mv && !f_mr;
        f_hold_d = f_md;
      end

      chk("fwd_occ", w_occ, w_q.size());
      if (w_hold) begin
        chk("fwd_stall_valid", w_mv, 1);
        chk("fwd_stall_data", w_md, w_hold_d);
      end
      if (w_fl) begin
        w_q.delete();
        w_hold = 0;
      end else begin
        if (w_mv && w_mr) begin
          if (w_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL fwd_unexpected_beat: got %0h expected none", w_md);
          end else begin
            chk("fwd_data", w_md, w_q.pop_front());
          end
        end
        if (w_sv && w_sr) w_q.push_back(w_sd);
        w_hold   = w_mv && !w_mr;
        w_hold_d = w_md;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present f_sd until accepted; reports stall cycles.
  task automatic f_send(input logic [15:0] d, output int stalls);
    bit acc;
    f_sv = 1'b1;
    f_sd = d;
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = f_sr;
      tick();
      if (acc) return;
      stalls++;
    end
    chk("full_send_timeout", 1, 0);
  endtask

  // One FWD cycle; new data only once the current beat is taken.
  task automatic w_cycle(input bit next_valid);
    bit acc;
    @(negedge clk);
    acc = w_sv && w_sr;
    tick();
    if (acc || !w_sv) begin
      w_sv = next_valid;
      w_sd = 16'($urandom);
    end
  endtask

  int stalls, tot_stalls;
  logic [7:0] bv;

  initial begin
    rst_n = 0;
    f_fl = 0; f_sv = 0; f_sd = '0; f_mr = 0;
    w_fl = 0; w_sv = 0; w_sd = '0; w_mr = 0;
    b_fl = 0; b_sv = 0; b_sd = '0; b_mr = 0;
    #2;
    chk("rst_full_mvalid", f_mv, 0);
    chk("rst_full_occ", f_occ, 0);
    chk("rst_full_sready", f_sr, 0);
    chk("rst_full_mdata", f_md, 0);
    chk("rst_fwd_sready", w_sr, 0);
    chk("rst_fwd_mvalid", w_mv, 0);
    repeat (2) tick();
    rst_n = 1;
    chk("rel_full_sready_before_edge", f_sr, 0);
    tick();
    chk("rel_full_sready_after_edge", f_sr, 1);
    chk("rel_fwd_sready_after_edge", w_sr, 1);

    // Stream 0x0100..0x0109 with m_ready held high
    f_mr = 1;
    lat_chk = 1;
    tot_stalls = 0;
    for (int i = 0; i < 10; i++) begin
      f_send(16'h0100 + 16'(i), stalls);
      tot_stalls += stalls;
    end
    f_sv = 0;
    chk("full_stream_stalls", tot_stalls, 0);
    repeat (4) tick();
    lat_chk = 0;
    chk("full_stream_drained", f_q.size(), 0);

    // Fill with downstream stalled
    f_mr = 0;
    for (int i = 0; i < 4; i++) begin
      f_send(16'($urandom), stalls);
    end
    f_sd = 16'($urandom);
    repeat (3) tick();
    chk("full_fill_occ", f_occ, 4);
    chk("full_fill_sready", f_sr, 0);
    f_sv = 0;
    f_mr = 1;
    repeat (6) tick();
    chk("full_drain_occ", f_occ, 0);
    chk("full_drain_mvalid", f_mv, 0);

    // FWD random traffic with m_ready alternating
    w_sv = 1'($urandom);
    w_sd = 16'($urandom);
    for (int c = 0; c < 200; c++) begin
      w_mr = (c % 2 == 0);
      w_cycle(1'($urandom));
    end
    w_sv = 0;
    w_mr = 1;
    repeat (6) tick();
    chk("fwd_random_drained", w_occ, 0);

    // FWD at capacity: simultaneous in/out holds occ, then flush
    w_mr = 0;
    w_sv = 1;
    w_sd = 16'($urandom);
    for (int c = 0; c < 6; c++) w_cycle(1'b1);
    chk("fwd_full_occ", w_occ, 3);
    chk("fwd_full_sready_stalled", w_sr, 0);
    w_mr = 1;
    @(negedge clk);
    chk("fwd_full_sready_mready", w_sr, 1);
    tick();
    chk("fwd_inout_occ_hold", w_occ, 3);
    w_fl = 1;
    w_sv = 1;
    w_sd = 16'hdead;
    @(negedge clk);
    chk("fwd_flush_sready", w_sr, 0);
    tick();
    w_fl = 0;
    w_sv = 0;
    chk("fwd_flush_occ", w_occ, 0);
    chk("fwd_flush_mvalid", w_mv, 0);
    chk("fwd_flush_mdata", w_md, 0);
    repeat (3) tick();
    chk("fwd_after_flush_mvalid", w_mv, 0);

    // Half-cycle reset pulse with two beats held in FULL
    f_mr = 0;
    f_send(16'h1111, stalls);
    f_send(16'h2222, stalls);
    f_sv = 0;
    @(negedge clk);
    chk("full_pre_reset_occ", f_occ, 2);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("pulse_full_mvalid", f_mv, 0);
    chk("pulse_full_occ", f_occ, 0);
    @(negedge clk);
    #1 rst_n = 1;
    chk("pulse_full_sready_before_edge", f_sr, 0);
    tick();
    chk("pulse_full_sready_after_edge", f_sr, 1);
    f_mr = 1;
    repeat (3) tick();
    chk("pulse_full_no_stale", f_mv, 0);

    // Bypass: pure wires, flush ignored
    for (int i = 0; i < 6; i++) begin
      bv   = (i == 0) ? 8'ha5 : 8'($urandom);
      b_sd = bv;
      b_sv = 1'($urandom);
      b_mr = 1'($urandom);
      b_fl = 1'(i % 2);
      #1;
      chk("byp_mdata", b_md, bv);
      chk("byp_mvalid", b_mv, b_sv);
      chk("byp_sready", b_sr, b_mr);
      chk("byp_occ", b_occ, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/syn_pipe_slice.md
SYN_PIPE_SLICE -- requirements
Module: syn_pipe_slice

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data bits per channel.
REQ-002 The block SHALL have parameter CH, default 1, meaning number of lock-step channels carried per beat.
REQ-003 The block SHALL have parameter STAGES, default 2, meaning register stages between slave and master ports; 0 SHALL be a combinational pass-through.
REQ-004 The block SHALL have parameter MODE, default PIPE_FULL, meaning the stage type: PIPE_FULL (skid, registered ready) or PIPE_FWD (forward-registered, combinational ready).
REQ-005 One clock and one reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous clear of all stored beats.
REQ-007 s_valid  input  1  upstream beat valid.
REQ-008 s_ready  output  1  block accepts a beat this cycle.
REQ-009 s_data  input  CH*DW  upstream beat; channel k in bits [k*DW +: DW].
REQ-010 m_valid  output  1  downstream beat valid.
REQ-011 m_ready  input  1  downstream accepts a beat.
REQ-012 m_data  output  CH*DW  downstream beat.
REQ-013 occ  output  OCC_W  beats held; OCC_W = clog2(CAP+1); CAP = 2*STAGES (FULL) or STAGES (FWD).

Function
REQ-014 A transfer SHALL occur on each port when valid and ready are both high at a rising clk edge.
REQ-015 Beats SHALL leave in acceptance order, with no loss, duplication or bit change, and all CH channels SHALL move together.
REQ-016 While m_valid=1 and m_ready=0, m_valid and m_data SHALL stay stable until the transfer.
REQ-017 With m_ready held high, an accepted beat SHALL appear on m_valid exactly STAGES cycles after its acceptance edge.
REQ-018 Throughput SHALL be one beat per cycle in both modes under continuous s_valid and m_ready.
REQ-019 In PIPE_FULL, each stage SHALL hold one main and one skid register, and its upstream ready SHALL be a flop equal to "skid empty".
REQ-020 In PIPE_FULL, no combinational path SHALL exist from m_ready to s_ready.
REQ-021 In PIPE_FWD, each stage's upstream ready SHALL be !valid_q || downstream_ready, so s_ready may depend combinationally on m_ready.
REQ-022 The stage state SHALL be EMPTY, ONE (main full) or TWO (main and skid full; FULL mode only).
REQ-023 Stage transitions: EMPTY→ONE on an input beat; ONE→EMPTY on output only; ONE→ONE on input and output together; ONE→TWO on input with a stalled output; TWO→ONE on output (skid moves to main).
REQ-024 A stage SHALL NOT accept input in state TWO.
REQ-025 occ SHALL increment on an s-transfer only, decrement on an m-transfer only, and hold when both occur in the same cycle.
REQ-026 occ SHALL never exceed CAP or wrap below 0, and s_ready SHALL be 0 whenever occ=CAP.
REQ-027 When flush=1 at an edge, all stages SHALL be EMPTY, occ=0 and data registers=0 after that edge.
REQ-028 During the flush cycle s_ready SHALL be 0, and any s or m handshake in that cycle SHALL be discarded.
REQ-029 With STAGES=0, m_valid=s_valid, m_data=s_data, s_ready=m_ready and occ=0, in both modes; flush SHALL have no effect.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously force all stages to EMPTY, all data registers to 0, m_valid=0, m_data=0 and occ=0.
REQ-031 During reset, s_ready SHALL be 0.
REQ-032 In PIPE_FULL, s_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-033 Reset mid-transfer SHALL discard all held beats, with no partial beat emitted afterwards.

Structure
REQ-034 Package syn_pipe_pkg SHALL hold the pipe_mode_e enum (PIPE_FULL, PIPE_FWD) and the stage-state enum (EMPTY, ONE, TWO).
REQ-035 One sub-module, syn_pipe_stage (a single-stage slice with the MODE parameter), SHALL be instantiated STAGES times in a generate chain.
REQ-036 The occ counter and the flush fan-out SHALL reside in syn_pipe_slice.

Verification
REQ-037 DW=8, CH=2, STAGES=2, FULL: beats 0x0100..0x0109 streamed, m_ready=1 → identical sequence out, first m_valid 2 cycles after the first acceptance, 1 beat/cycle.
REQ-038 FULL, STAGES=2, m_ready=0, s_valid=1 → 4 beats accepted, occ=4, then s_ready=0; m_ready raised → 4 beats out in order, then occ=0.
REQ-039 FWD, STAGES=3, m_ready toggled 1010…, random s_valid → scoreboard matches, m_data stable during stalls, occ never exceeds 3.
REQ-040 occ=3 with s- and m-transfers in the same cycle → occ stays 3; flush asserted at occ=3 → occ=0, m_valid=0 next cycle, and a handshake in the flush cycle is discarded.
REQ-041 rst_n pulsed low for half a cycle at occ=2 → m_valid=0, occ=0 immediately; no stale beat afterwards; s_ready=1 one edge after release.
REQ-042 STAGES=0 → s_data 0xA5 appears on m_data in the same cycle, and s_ready follows m_ready.
